// File: rtl/fixed_dotn_pipe.sv
// Pipelined signed fixed-point N-component dot product with per-transaction rounding/saturation,
// overflow flag and counter, tag passthrough and valid/ready flow control.
module fixed_dotn_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 28,
  parameter int unsigned N     = 3,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   a,
  input  logic [N*WIDTH-1:0]   b,
  input  logic                 rnd,
  input  logic                 sat,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic [TAG_W-1:0]     tag_out,
  output logic [CNT_W-1:0]     ovf_count,
  input  logic                 clr_count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + $clog2(N);

  logic                 advance;
  logic                 v1_q, v2_q, v3_q;
  logic                 rnd1_q, sat1_q, rnd2_q, sat2_q;
  logic [TAG_W-1:0]     tag1_q, tag2_q, tag3_q;
  logic signed [PW-1:0] a_ext [N];
  logic signed [PW-1:0] b_ext [N];
  logic signed [PW-1:0] prod_d [N];
  logic signed [PW-1:0] prod_q [N];
  logic signed [SW-1:0] sum_d, sum_q;
  logic signed [SW-1:0] rnd_add, rounded, shifted;
  logic                 in_range;
  logic [WIDTH-1:0]     res_d, res_q;
  logic                 ovf_d, ovf_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  // One global advance: every stage moves together, bubbles are kept.
  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign result    = res_q;
  assign ovf       = ovf_q;
  assign tag_out   = tag3_q;
  assign ovf_count = cnt_q;

  // S1: operands sign-extended to 2*WIDTH so each product is exact.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_ext[i]  = {{WIDTH{a[i*WIDTH+WIDTH-1]}}, a[i*WIDTH +: WIDTH]};
      b_ext[i]  = {{WIDTH{b[i*WIDTH+WIDTH-1]}}, b[i*WIDTH +: WIDTH]};
      prod_d[i] = a_ext[i] * b_ext[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum_d = sum_d + SW'(prod_q[i]);
    end
  end

  // S3: round, rescale, then range check on the bits above the result's sign bit.
  always_comb begin
    rnd_add = '0;
    if (rnd2_q) rnd_add[FRAC-1] = 1'b1;
    rounded  = sum_q + rnd_add;
    shifted  = rounded >>> FRAC;
    in_range = (&shifted[SW-1:WIDTH-1]) || !(|shifted[SW-1:WIDTH-1]);
    ovf_d    = !in_range;
    res_d    = shifted[WIDTH-1:0];
    if (ovf_d && sat2_q) begin
      res_d = shifted[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (v3_q && out_ready && ovf_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      rnd1_q <= 1'b0;
      sat1_q <= 1'b0;
      rnd2_q <= 1'b0;
      sat2_q <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      for (int unsigned i = 0; i < N; i++) prod_q[i] <= '0;
      sum_q  <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        v1_q   <= in_valid;
        v2_q   <= v1_q;
        v3_q   <= v2_q;
        rnd1_q <= rnd;
        sat1_q <= sat;
        rnd2_q <= rnd1_q;
        sat2_q <= sat1_q;
        tag1_q <= tag_in;
        tag2_q <= tag1_q;
        tag3_q <= tag2_q;
        for (int unsigned i = 0; i < N; i++) prod_q[i] <= prod_d[i];
        sum_q  <= sum_d;
        res_q  <= res_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule
